// File: rtl/reflex_judge.sv
// -----------------------------------------------------------------------------
// reflex_judge
//
// Round judge for the reflex game. Each edge of the round timer output
// (clk_4s) opens a new round and lights one pseudo-random target LED. The
// judge classifies player presses as hit, wrong or miss, keeps the score,
// and reports wrong_time back to the round timer. The timer stops toggling
// once wrong_time reaches 3.
//
// Optional feature (macro REFLEX_TIMEOUT_EN):
//   When the macro is defined, each armed round has a reaction window of
//   TIMEOUT_CYC clk cycles. If the window expires with no press, the round
//   counts as a miss. When the macro is not defined, the window lasts until
//   the next round edge.
//
// Ports:
//   clk        in   system clock, single clock domain
//   rst_n      in   asynchronous active-low reset
//   switch     in   game enable; rising edge starts a new game
//   clk_4s     in   round timer output, synchronous to clk; each edge = new round
//   btn        in   raw player buttons, active-high, asynchronous
//   target     out  one-hot lit LED, 0 when no round is armed
//   hit_pulse  out  single-cycle pulse on a correct press
//   score      out  correct hits, saturating
//   wrong_time out  wrong presses plus misses, saturating at 7
//   game_over  out  high while the game is over
// -----------------------------------------------------------------------------
module reflex_judge #(
    parameter int N_TARGETS   = 4,
    parameter int SCORE_W     = 8,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 switch,
    input  logic                 clk_4s,
    input  logic [N_TARGETS-1:0] btn,
    output logic [N_TARGETS-1:0] target,
    output logic                 hit_pulse,
    output logic [SCORE_W-1:0]   score,
    output logic [2:0]           wrong_time,
    output logic                 game_over
);

    localparam int IW = $clog2(N_TARGETS);

    // Reject parameter values the target encoding cannot handle.
    if ((N_TARGETS != 2 && N_TARGETS != 4 && N_TARGETS != 8) || TIMEOUT_CYC < 1) begin : g_param_check
        $error("reflex_judge: N_TARGETS must be 2, 4 or 8 and TIMEOUT_CYC at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ARMED,
        RESOLVED,
        OVER
    } state_t;

    state_t                 state, state_n;
    logic [N_TARGETS-1:0]   btn_s1, btn_s2, btn_s3;
    logic                   clk_4s_q;
    logic                   switch_q;
    logic [15:0]            lfsr;
    logic [IW-1:0]          prev_idx;

    logic [N_TARGETS-1:0]   press;
    logic                   round_edge;
    logic                   switch_rise;
    logic                   lfsr_fb;
    logic [IW-1:0]          lfsr_idx;
    logic [IW-1:0]          new_idx;
    logic [N_TARGETS-1:0]   new_target;
    logic [SCORE_W-1:0]     score_inc;
    logic [2:0]             wrong_inc;
    logic                   timeout;
    logic                   load;

    logic [N_TARGETS-1:0]   target_n;
    logic                   hit_n;
    logic [SCORE_W-1:0]     score_n;
    logic [2:0]             wrong_n;
    logic                   game_over_n;

    // btn_s1/btn_s2 form the synchroniser; btn_s3 is the previous synchronised
    // value used for rising-edge detection. A press therefore reaches the
    // judging logic on the third clock edge after the button rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_s3   <= '0;
            clk_4s_q <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            btn_s1   <= btn;
            btn_s2   <= btn_s1;
            btn_s3   <= btn_s2;
            clk_4s_q <= clk_4s;
            switch_q <= switch;
        end
    end

    assign press       = btn_s2 & ~btn_s3;
    assign round_edge  = clk_4s ^ clk_4s_q;
    assign switch_rise = switch & ~switch_q;

    // Fibonacci LFSR, taps 16,14,13,11, free-running so the target depends on
    // when the round edge arrives.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    // Bumping a repeated index by one (wrapping) guarantees that two
    // consecutive rounds never light the same LED.
    assign lfsr_idx   = lfsr[IW-1:0];
    assign new_idx    = (lfsr_idx == prev_idx) ? lfsr_idx + IW'(1) : lfsr_idx;
    assign new_target = N_TARGETS'(1) << new_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_idx <= '0;
        end else if (load) begin
            prev_idx <= new_idx;
        end
    end

`ifdef REFLEX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;

    // Counts cycles spent in ARMED since the last target load; the count
    // parks at its terminal value because the round resolves right there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (load) begin
            tmo_cnt <= '0;
        end else if (state == ARMED && tmo_cnt != TW'(TIMEOUT_CYC - 1)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign timeout = (state == ARMED) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    assign score_inc = (score == {SCORE_W{1'b1}}) ? score : score + SCORE_W'(1);
    assign wrong_inc = (wrong_time == 3'd7) ? wrong_time : wrong_time + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= '0;
            hit_pulse  <= 1'b0;
            score      <= '0;
            wrong_time <= '0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            hit_pulse  <= hit_n;
            score      <= score_n;
            wrong_time <= wrong_n;
            game_over  <= game_over_n;
        end
    end

    // Dropping switch overrides everything. While playing, a registered
    // wrong_time of 3 or more ends the game before any other event is looked
    // at. In ARMED a press is judged against the current target even if a
    // round edge arrives in the same cycle; the round edge then only loads
    // the next target, and counts a miss when no press accompanied it.
    always_comb begin
        state_n  = state;
        target_n = target;
        hit_n    = 1'b0;
        score_n  = score;
        wrong_n  = wrong_time;
        load     = 1'b0;

        if (!switch) begin
            state_n  = IDLE;
            target_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    target_n = '0;
                    if (switch_rise) begin
                        score_n = '0;
                        wrong_n = '0;
                        state_n = WAIT;
                    end
                end
                WAIT, RESOLVED: begin
                    if (wrong_time >= 3'd3) begin
                        state_n  = OVER;
                        target_n = '0;
                    end else if (round_edge) begin
                        load     = 1'b1;
                        target_n = new_target;
                        state_n  = ARMED;
                    end else begin
                        target_n = '0;
                    end
                end
                ARMED: begin
                    if (wrong_time >= 3'd3) begin
                        state_n  = OVER;
                        target_n = '0;
                    end else begin
                        if (press != '0) begin
                            if (press == target) begin
                                score_n = score_inc;
                                hit_n   = 1'b1;
                            end else begin
                                wrong_n = wrong_inc;
                            end
                            state_n  = RESOLVED;
                            target_n = '0;
                        end else if (timeout) begin
                            wrong_n  = wrong_inc;
                            state_n  = RESOLVED;
                            target_n = '0;
                        end
                        if (round_edge) begin
                            if (press == '0) begin
                                wrong_n = wrong_inc;
                            end
                            load     = 1'b1;
                            target_n = new_target;
                            state_n  = ARMED;
                        end
                    end
                end
                OVER: begin
                    target_n = '0;
                end
                default: begin
                    state_n  = IDLE;
                    target_n = '0;
                end
            endcase
        end

        game_over_n = (state_n == OVER);
    end

endmodule

// File: tb/tb_reflex_judge.sv
// -----------------------------------------------------------------------------
// tb_reflex_judge
//
// Self-checking bench for reflex_judge. Expected score / wrong_time / hit
// values are kept by the bench, pushed to a scoreboard queue as each press or
// round edge is driven, and popped when the judge reacts.
// -----------------------------------------------------------------------------
module tb_reflex_judge;

    localparam int N   = 4;
    localparam int SW  = 8;
    localparam int TMO = 100;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          switch = 1'b0;
    logic          clk_4s = 1'b0;
    logic [N-1:0]  btn    = '0;
    logic [N-1:0]  target;
    logic          hit_pulse;
    logic [SW-1:0] score;
    logic [2:0]    wrong_time;
    logic          game_over;

    typedef struct packed {
        logic [SW-1:0] score;
        logic [2:0]    wrong;
        logic          hit;
    } exp_t;

    exp_t          sb[$];
    logic [SW-1:0] exp_score = '0;
    logic [2:0]    exp_wrong = '0;
    int            vectors     = 0;
    int            miscompares = 0;

    reflex_judge #(
        .N_TARGETS  (N),
        .SCORE_W    (SW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .switch    (switch),
        .clk_4s    (clk_4s),
        .btn       (btn),
        .target    (target),
        .hit_pulse (hit_pulse),
        .score     (score),
        .wrong_time(wrong_time),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bump_score();
        exp_score = (exp_score == {SW{1'b1}}) ? exp_score : exp_score + SW'(1);
    endtask

    task automatic restart_game();
        switch = 1'b0;
        cyc(2);
        switch = 1'b1;
        cyc(2);
        exp_score = '0;
        exp_wrong = '0;
    endtask

    // Waits until the judge reacts (hit pulse or wrong_time change) and
    // returns what it saw at that moment.
    task automatic await_judge(input int budget, output bit ok, output exp_t obs);
        logic [2:0] w0;
        w0 = wrong_time;
        ok = 1'b0;
        obs = '0;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (hit_pulse || wrong_time != w0) begin
                ok = 1'b1;
                break;
            end
        end
        obs.score = score;
        obs.wrong = wrong_time;
        obs.hit   = hit_pulse;
    endtask

    // One full round: open it, press the lit button, release.
    task automatic play_round(output bit ok, output logic [N-1:0] tgt, output exp_t obs);
        clk_4s = ~clk_4s;
        cyc(1);
        tgt = target;
        btn = target;
        bump_score();
        sb.push_back('{score: exp_score, wrong: exp_wrong, hit: 1'b1});
        await_judge(6, ok, obs);
        btn = '0;
        cyc(3);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        switch = 1'b0;
        btn    = '0;
        clk_4s = 1'b0;
        cyc(3);
        vectors++; if (target !== '0) begin miscompares++; $display("[TB] FAIL reset_target: got %0h expected 0", target); end
        vectors++; if (hit_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_hit: got %0b expected 0", hit_pulse); end
        vectors++; if (score !== '0) begin miscompares++; $display("[TB] FAIL reset_score: got %0d expected 0", score); end
        vectors++; if (wrong_time !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_wrong: got %0d expected 0", wrong_time); end
        vectors++; if (game_over !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_over: got %0b expected 0", game_over); end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_idle();
        clk_4s = ~clk_4s;
        cyc(2);
        vectors++; if (target !== '0) begin miscompares++; $display("[TB] FAIL idle_target: got %0h expected 0", target); end
    endtask

    task automatic test_hit();
        bit           ok;
        logic [N-1:0] tgt;
        exp_t         obs, e;
        restart_game();
        play_round(ok, tgt, obs);
        e = sb.pop_front();
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL hit_timeout: got no reaction, required a hit"); end
        vectors++; if ($onehot(tgt) !== 1'b1) begin miscompares++; $display("[TB] FAIL hit_onehot: got %0h required one-hot", tgt); end
        vectors++; if (obs.hit !== e.hit) begin miscompares++; $display("[TB] FAIL hit_pulse: got %0b expected %0b", obs.hit, e.hit); end
        vectors++; if (obs.score !== e.score) begin miscompares++; $display("[TB] FAIL hit_score: got %0d expected %0d", obs.score, e.score); end
        vectors++; if (obs.wrong !== e.wrong) begin miscompares++; $display("[TB] FAIL hit_wrong: got %0d expected %0d", obs.wrong, e.wrong); end
        vectors++; if (hit_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_pulse_width: got %0b expected 0", hit_pulse); end
        vectors++; if (target !== '0) begin miscompares++; $display("[TB] FAIL hit_resolved_target: got %0h expected 0", target); end
        btn = '1;
        cyc(5);
        vectors++; if (score !== exp_score) begin miscompares++; $display("[TB] FAIL resolved_ignore_score: got %0d expected %0d", score, exp_score); end
        vectors++; if (wrong_time !== exp_wrong) begin miscompares++; $display("[TB] FAIL resolved_ignore_wrong: got %0d expected %0d", wrong_time, exp_wrong); end
        btn = '0;
        cyc(3);
    endtask

    task automatic test_back_to_back();
        bit           ok;
        logic [N-1:0] t_old, t_new;
        exp_t         obs, e;
        clk_4s = ~clk_4s;
        cyc(1);
        t_old = target;
        btn = t_old;
        bump_score();
        sb.push_back('{score: exp_score, wrong: exp_wrong, hit: 1'b1});
        cyc(2);
        clk_4s = ~clk_4s;
        cyc(1);
        e = sb.pop_front();
        t_new = target;
        vectors++; if (hit_pulse !== e.hit) begin miscompares++; $display("[TB] FAIL b2b_hit: got %0b expected %0b", hit_pulse, e.hit); end
        vectors++; if (score !== e.score) begin miscompares++; $display("[TB] FAIL b2b_score: got %0d expected %0d", score, e.score); end
        vectors++; if (wrong_time !== e.wrong) begin miscompares++; $display("[TB] FAIL b2b_wrong: got %0d expected %0d", wrong_time, e.wrong); end
        vectors++; if ($onehot(t_new) !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_new_target: got %0h required one-hot", t_new); end
        vectors++; if (t_new === t_old) begin miscompares++; $display("[TB] FAIL b2b_repeat: got %0h required different from %0h", t_new, t_old); end
        btn = '0;
        cyc(3);
        btn = target;
        bump_score();
        sb.push_back('{score: exp_score, wrong: exp_wrong, hit: 1'b1});
        await_judge(6, ok, obs);
        e = sb.pop_front();
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_followup_timeout: got no reaction, required a hit"); end
        vectors++; if (obs.score !== e.score) begin miscompares++; $display("[TB] FAIL b2b_followup_score: got %0d expected %0d", obs.score, e.score); end
        btn = '0;
        cyc(3);
    endtask

    task automatic test_many_rounds();
        bit           ok;
        logic [N-1:0] tgt, prev;
        exp_t         obs, e;
        restart_game();
        vectors++; if (score !== '0) begin miscompares++; $display("[TB] FAIL restart_score: got %0d expected 0", score); end
        prev = '0;
        for (int i = 0; i < 260; i++) begin
            play_round(ok, tgt, obs);
            e = sb.pop_front();
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL round%0d_timeout: got no reaction, required a hit", i); end
            vectors++; if ($onehot(tgt) !== 1'b1) begin miscompares++; $display("[TB] FAIL round%0d_onehot: got %0h required one-hot", i, tgt); end
            vectors++; if (tgt === prev) begin miscompares++; $display("[TB] FAIL round%0d_repeat: got %0h required different from %0h", i, tgt, prev); end
            vectors++; if (obs.score !== e.score) begin miscompares++; $display("[TB] FAIL round%0d_score: got %0d expected %0d", i, obs.score, e.score); end
            prev = tgt;
            if (i == 199) begin
                vectors++; if (score !== SW'(200)) begin miscompares++; $display("[TB] FAIL score_200: got %0d expected 200", score); end
            end
        end
        vectors++; if (score !== {SW{1'b1}}) begin miscompares++; $display("[TB] FAIL score_saturate: got %0d expected %0d", score, {SW{1'b1}}); end
    endtask

    task automatic test_wrong_miss_over();
        bit           ok;
        logic [N-1:0] tgt;
        exp_t         obs, e;
        restart_game();
        clk_4s = ~clk_4s;
        cyc(1);
        tgt = target;
        btn = {tgt[N-2:0], tgt[N-1]};
        exp_wrong = 3'd1;
        sb.push_back('{score: exp_score, wrong: exp_wrong, hit: 1'b0});
        await_judge(6, ok, obs);
        e = sb.pop_front();
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL wrong_timeout: got no reaction, required wrong"); end
        vectors++; if (obs.wrong !== e.wrong) begin miscompares++; $display("[TB] FAIL wrong_count: got %0d expected %0d", obs.wrong, e.wrong); end
        vectors++; if (obs.hit !== e.hit) begin miscompares++; $display("[TB] FAIL wrong_hit: got %0b expected %0b", obs.hit, e.hit); end
        btn = '0;
        cyc(3);
        clk_4s = ~clk_4s;
        cyc(1);
        clk_4s = ~clk_4s;
        exp_wrong = 3'd2;
        sb.push_back('{score: exp_score, wrong: exp_wrong, hit: 1'b0});
        await_judge(4, ok, obs);
        e = sb.pop_front();
        vectors++; if (obs.wrong !== e.wrong) begin miscompares++; $display("[TB] FAIL miss_count: got %0d expected %0d", obs.wrong, e.wrong); end
        vectors++; if ($onehot(target) !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_new_target: got %0h required one-hot", target); end
        btn = '1;
        exp_wrong = 3'd3;
        sb.push_back('{score: exp_score, wrong: exp_wrong, hit: 1'b0});
        await_judge(6, ok, obs);
        e = sb.pop_front();
        vectors++; if (obs.wrong !== e.wrong) begin miscompares++; $display("[TB] FAIL multi_press_wrong: got %0d expected %0d", obs.wrong, e.wrong); end
        vectors++; if (obs.score !== e.score) begin miscompares++; $display("[TB] FAIL multi_press_score: got %0d expected %0d", obs.score, e.score); end
        btn = '0;
        cyc(1);
        vectors++; if (game_over !== 1'b1) begin miscompares++; $display("[TB] FAIL over_flag: got %0b expected 1", game_over); end
        vectors++; if (target !== '0) begin miscompares++; $display("[TB] FAIL over_target: got %0h expected 0", target); end
        for (int i = 0; i < 3; i++) begin
            clk_4s = ~clk_4s;
            cyc(2);
            vectors++; if (target !== '0) begin miscompares++; $display("[TB] FAIL over_toggle%0d_target: got %0h expected 0", i, target); end
        end
        vectors++; if (wrong_time !== 3'd3) begin miscompares++; $display("[TB] FAIL over_wrong_hold: got %0d expected 3", wrong_time); end
        switch = 1'b0;
        cyc(1);
        vectors++; if (game_over !== 1'b0) begin miscompares++; $display("[TB] FAIL switch_off_over: got %0b expected 0", game_over); end
        vectors++; if (wrong_time !== 3'd3) begin miscompares++; $display("[TB] FAIL switch_off_wrong: got %0d expected 3", wrong_time); end
        cyc(2);
    endtask

    task automatic test_timeout();
        restart_game();
        clk_4s = ~clk_4s;
        cyc(1);
`ifdef REFLEX_TIMEOUT_EN
        cyc(TMO - 1);
        vectors++; if (wrong_time !== exp_wrong) begin miscompares++; $display("[TB] FAIL timeout_early: got %0d expected %0d", wrong_time, exp_wrong); end
        cyc(1);
        exp_wrong = exp_wrong + 3'd1;
        vectors++; if (wrong_time !== exp_wrong) begin miscompares++; $display("[TB] FAIL timeout_miss: got %0d expected %0d", wrong_time, exp_wrong); end
        vectors++; if (target !== '0) begin miscompares++; $display("[TB] FAIL timeout_target: got %0h expected 0", target); end
`else
        cyc(150);
        vectors++; if (wrong_time !== exp_wrong) begin miscompares++; $display("[TB] FAIL no_timeout_wrong: got %0d expected %0d", wrong_time, exp_wrong); end
        vectors++; if ($onehot(target) !== 1'b1) begin miscompares++; $display("[TB] FAIL no_timeout_target: got %0h required one-hot", target); end
        clk_4s = ~clk_4s;
        cyc(1);
        exp_wrong = exp_wrong + 3'd1;
        vectors++; if (wrong_time !== exp_wrong) begin miscompares++; $display("[TB] FAIL edge_miss: got %0d expected %0d", wrong_time, exp_wrong); end
`endif
    endtask

    task automatic test_async_reset();
        bit           ok;
        logic [N-1:0] tgt;
        exp_t         obs, e;
        restart_game();
        for (int i = 0; i < 5; i++) begin
            play_round(ok, tgt, obs);
            e = sb.pop_front();
            vectors++; if (obs.score !== e.score) begin miscompares++; $display("[TB] FAIL pre_reset%0d_score: got %0d expected %0d", i, obs.score, e.score); end
        end
        clk_4s = ~clk_4s;
        cyc(1);
        vectors++; if (score !== SW'(5)) begin miscompares++; $display("[TB] FAIL pre_reset_score: got %0d expected 5", score); end
        #2;
        rst_n  = 1'b0;
        switch = 1'b0;
        #1;
        vectors++; if (target !== '0) begin miscompares++; $display("[TB] FAIL async_target: got %0h expected 0", target); end
        vectors++; if (score !== '0) begin miscompares++; $display("[TB] FAIL async_score: got %0d expected 0", score); end
        vectors++; if (wrong_time !== 3'd0) begin miscompares++; $display("[TB] FAIL async_wrong: got %0d expected 0", wrong_time); end
        vectors++; if (hit_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL async_hit: got %0b expected 0", hit_pulse); end
        vectors++; if (game_over !== 1'b0) begin miscompares++; $display("[TB] FAIL async_over: got %0b expected 0", game_over); end
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        clk_4s = ~clk_4s;
        cyc(2);
        vectors++; if (target !== '0) begin miscompares++; $display("[TB] FAIL post_reset_idle: got %0h expected 0", target); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_hit();
        test_back_to_back();
        test_many_rounds();
        test_wrong_miss_over();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
